// File: rtl/gpu_pkg.sv
// -----------------------------------------------------------------------------
// gpu_pkg
// Constants shared between the instruction-memory server and the SIMD cores.
//   NUM_SIMD_CORES : default number of cores that fetch from the shared store.
//   RET_INSTR      : instruction word the cores decode as "return"; the
//                    server also sends it back for out-of-range fetches.
//   instr_t        : one 32-bit instruction word.
// -----------------------------------------------------------------------------
package gpu_pkg;

  localparam int          NUM_SIMD_CORES = 4;
  localparam logic [31:0] RET_INSTR      = 32'hFFFF_FFFF;

  typedef logic [31:0] instr_t;

endpackage : gpu_pkg

// File: rtl/imem_server_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational N-way round-robin arbiter. The search for a set request bit
// starts at index ptr and wraps around. The pointer register is owned by the
// instantiating module.
// Ports:
//   req       in  [N]      request vector
//   ptr       in  [PTR_W]  index where the search starts (must be < N)
//   grant     out [N]      one-hot grant, all zero when req is zero
//   grant_idx out [PTR_W]  index of the granted bit, zero when nothing granted
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] grant_idx
);

  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;

  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    grant     = '0;
    grant_idx = '0;
    sum       = '0;
    idx       = '0;
    // Walk from the farthest offset down to zero: the last hit written is the
    // one closest to ptr, which is the round-robin winner.
    for (int off = N - 1; off >= 0; off--) begin
      sum = {1'b0, ptr} + (PTR_W + 1)'(off);
      if (sum >= (PTR_W + 1)'(N)) begin
        sum = sum - (PTR_W + 1)'(N);
      end
      idx = sum[PTR_W-1:0];
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/imem_server.sv
// -----------------------------------------------------------------------------
// imem_server
// Shared instruction-memory responder. Every SIMD core may hold one outstanding
// fetch; a round-robin arbiter picks one pending core per cycle, the store is
// read at its latched address, and the word is returned one cycle later with a
// single-cycle instr_valid strobe. Program-load writes take priority over
// fetches: in a write cycle nothing is granted and the pointer holds.
//
// Optional feature (macro IMEM_BOUNDS_CHECK_EN): addresses >= IMEM_DEPTH return
// RET_INSTR and set a sticky per-core fetch_fault flag. Without it, the upper
// address bits are ignored and addresses wrap.
//
// Ports:
//   clk, rst     clock; asynchronous active-high reset
//   fetch_req    [N]      per-core request
//   fetch_addr   [32*N]   per-core word address, core i at [32*i +: 32]
//   fetch_ready  [N]      core i may issue (no request outstanding)
//   instr_valid  [N]      one-cycle response strobe
//   instr_out    [32*N]   returned word, held until the next response
//   prog_we / prog_addr / prog_data   program-load write port
//   fetch_fault  [N]      sticky out-of-range flag (bounds-check build only)
// -----------------------------------------------------------------------------
module imem_server #(
  parameter int NUM_SIMD_CORES  = gpu_pkg::NUM_SIMD_CORES,
  parameter int IMEM_DEPTH      = 256,
  parameter int LOG2_IMEM_DEPTH = $clog2(IMEM_DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_SIMD_CORES-1:0]    fetch_req,
  input  logic [32*NUM_SIMD_CORES-1:0] fetch_addr,
  output logic [NUM_SIMD_CORES-1:0]    fetch_ready,
  output logic [NUM_SIMD_CORES-1:0]    instr_valid,
  output logic [32*NUM_SIMD_CORES-1:0] instr_out,
  input  logic                         prog_we,
  input  logic [LOG2_IMEM_DEPTH-1:0]   prog_addr,
  input  logic [31:0]                  prog_data
`ifdef IMEM_BOUNDS_CHECK_EN
  ,
  output logic [NUM_SIMD_CORES-1:0]    fetch_fault
`endif
);

  import gpu_pkg::*;

  localparam int PTR_W = (NUM_SIMD_CORES > 1) ? $clog2(NUM_SIMD_CORES) : 1;

  instr_t                    mem [IMEM_DEPTH];
  logic [NUM_SIMD_CORES-1:0] pending;
  logic [31:0]               addr_q [NUM_SIMD_CORES];
  logic [PTR_W-1:0]          rr_ptr;

  logic [NUM_SIMD_CORES-1:0] arb_req;
  logic [NUM_SIMD_CORES-1:0] grant;
  logic [PTR_W-1:0]          grant_idx;
  logic                      grant_any;
  logic [31:0]               grant_addr;
  instr_t                    read_word;

  assign fetch_ready = ~pending;

  // A program-load cycle owns the single store port, so it masks every request.
  assign arb_req   = prog_we ? '0 : pending;
  assign grant_any = |grant;

  rr_arbiter #(
    .N     (NUM_SIMD_CORES),
    .PTR_W (PTR_W)
  ) u_arb (
    .req       (arb_req),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign grant_addr = addr_q[grant_idx];

`ifdef IMEM_BOUNDS_CHECK_EN
  logic out_of_range;
  assign out_of_range = |(grant_addr >> LOG2_IMEM_DEPTH);
  assign read_word    = out_of_range ? RET_INSTR
                                     : mem[grant_addr[LOG2_IMEM_DEPTH-1:0]];
`else
  // Upper address bits are deliberately dropped: fetches wrap modulo depth.
  logic unused_addr_hi;
  assign unused_addr_hi = ^grant_addr[31:LOG2_IMEM_DEPTH];
  assign read_word      = mem[grant_addr[LOG2_IMEM_DEPTH-1:0]];
`endif

  // NOTE: the store has no reset; program load defines its contents, and
  // keeping reset off the array lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (prog_we) begin
      mem[prog_addr] <= prog_data;
    end
  end

  // NOTE: all state registers use non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending     <= '0;
      rr_ptr      <= '0;
      instr_valid <= '0;
      instr_out   <= '0;
      for (int i = 0; i < NUM_SIMD_CORES; i++) begin
        addr_q[i] <= '0;
      end
`ifdef IMEM_BOUNDS_CHECK_EN
      fetch_fault <= '0;
`endif
    end else begin
      instr_valid <= grant;
      if (grant_any) begin
        rr_ptr <= (grant_idx == PTR_W'(NUM_SIMD_CORES - 1)) ? '0
                                                             : grant_idx + 1'b1;
      end
      for (int i = 0; i < NUM_SIMD_CORES; i++) begin
        // Grant requires pending and accept requires !pending, so at most one
        // of these branches can apply to a core in any cycle.
        if (grant[i]) begin
          pending[i]           <= 1'b0;
          instr_out[32*i +: 32] <= read_word;
`ifdef IMEM_BOUNDS_CHECK_EN
          if (out_of_range) begin
            fetch_fault[i] <= 1'b1;
          end
`endif
        end else if (fetch_req[i] && !pending[i]) begin
          pending[i] <= 1'b1;
          addr_q[i]  <= fetch_addr[32*i +: 32];
        end
      end
    end
  end

endmodule : imem_server
